// File: rtl/mini_core_local_port_ctrl_if.sv
// Shared transaction types and the local-port bundle between tile core, controller and router.
// The controller takes the slave view; the core/router side (or a bench) takes the master view.
package mini_core_pkg;
   typedef struct packed {
      logic [3:0]  dst;
      logic [3:0]  src;
      logic [23:0] data;
   } t_tile_trans;

   typedef logic [3:0] t_fab_ready;
endpackage

interface mini_core_local_port_ctrl_if
   import mini_core_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int RX_DEPTH = 4
) ();
   // core-side injection requesters
   logic [NUM_REQ-1:0]                req_valid;
   t_tile_trans [NUM_REQ-1:0]         req_trans;
   logic [NUM_REQ-1:0]                req_ready;
   // injection towards the router local input
   logic                              in_local_req_valid;
   t_tile_trans                       in_local_req;
   t_fab_ready                        out_local_ready;
   // ejection from the router local output
   logic                              out_local_req_valid;
   t_tile_trans                       out_local_req;
   t_fab_ready                        in_local_ready;
   // core-side RX pop port and status
   logic                              rx_valid;
   t_tile_trans                       rx_trans;
   logic                              rx_ready;
   logic [$clog2(RX_DEPTH+1)-1:0]     rx_count;
   logic [$clog2(NUM_REQ)-1:0]        grant_id;

   modport slave (
      input  req_valid, req_trans, out_local_ready, out_local_req_valid, out_local_req, rx_ready,
      output req_ready, in_local_req_valid, in_local_req, in_local_ready,
             rx_valid, rx_trans, rx_count, grant_id
   );

   modport master (
      output req_valid, req_trans, out_local_ready, out_local_req_valid, out_local_req, rx_ready,
      input  req_ready, in_local_req_valid, in_local_req, in_local_ready,
             rx_valid, rx_trans, rx_count, grant_id
   );
endinterface

// File: rtl/mini_core_local_port_ctrl.sv
// Tile local-port controller: round-robin injection arbiter with a one-entry holding register, plus RX FIFO.
// Latency: injection 1 cycle from req_ready to in_local_req_valid; RX 1 cycle from write to rx_valid.
// Backpressure: injection holds until all four router arbiters are ready; RX ready drops when the FIFO is full.
module mini_core_local_port_ctrl
   import mini_core_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int RX_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   mini_core_local_port_ctrl_if.slave  lp
);
   localparam int GW = $clog2(NUM_REQ);
   localparam int CW = $clog2(RX_DEPTH + 1);
   localparam int PW = $clog2(RX_DEPTH);

   typedef enum logic {ST_IDLE, ST_HOLD} t_inj_state;

   // ------------------------------------------------------------------
   // Injection path
   // ------------------------------------------------------------------
   t_inj_state        state_q, state_d;
   logic [GW-1:0]     grant_q;
   logic [GW-1:0]     win_id;
   logic              win_vld;
   logic              inj_go;
   logic              acc_en;
   logic              acc_vld;
   t_tile_trans       hold_q;

   assign inj_go = (state_q == ST_HOLD) && (&lp.out_local_ready);

   // Search starts just after the last winner so every requester is served within NUM_REQ grants.
   always_comb begin
      int            idx;
      logic [GW-1:0] idx_g;
      win_vld = 1'b0;
      win_id  = grant_q;
      idx     = 0;
      idx_g   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx   = (int'(grant_q) + i) % NUM_REQ;
         idx_g = GW'(idx);
         if (!win_vld && lp.req_valid[idx_g]) begin
            win_vld = 1'b1;
            win_id  = idx_g;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      acc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            acc_en = 1'b1;
            if (win_vld) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            if (inj_go) begin
               acc_en  = 1'b1;
               state_d = win_vld ? ST_HOLD : ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign acc_vld = rst && acc_en && win_vld;

   always_comb begin
      lp.req_ready = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         lp.req_ready[j] = acc_vld && (win_id == GW'(j));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         grant_q <= GW'(NUM_REQ - 1);
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         if (acc_vld) begin
            hold_q  <= lp.req_trans[win_id];
            grant_q <= win_id;
         end
      end
   end

   assign lp.in_local_req_valid = (state_q == ST_HOLD);
   assign lp.in_local_req       = hold_q;
   assign lp.grant_id           = grant_q;

   // ------------------------------------------------------------------
   // RX FIFO
   // ------------------------------------------------------------------
   t_tile_trans       mem_q [RX_DEPTH];
   logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q;
   logic              not_full;
   logic              wr_en, rd_en;

   assign not_full = (count_q < CW'(RX_DEPTH));
   assign wr_en    = rst && lp.out_local_req_valid && not_full;
   assign rd_en    = rst && (count_q != '0) && lp.rx_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({wr_en, rd_en})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: the occupancy count alone decides what is visible.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= lp.out_local_req;
   end

   assign lp.rx_valid       = (count_q != '0);
   assign lp.rx_trans       = mem_q[rd_ptr_q];
   assign lp.rx_count       = count_q;
   assign lp.in_local_ready = (rst && not_full) ? 4'b1111 : 4'b0000;

   // ------------------------------------------------------------------
   // Protocol checks
   // ------------------------------------------------------------------
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      !(lp.out_local_req_valid && !not_full));

   a_req_ready_onehot: assert property (@(posedge clk) $onehot0(lp.req_ready));

   a_count_bounded: assert property (@(posedge clk) disable iff (!rst)
      count_q <= CW'(RX_DEPTH));

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
      (state_q == ST_HOLD && !inj_go) |=> (state_q == ST_HOLD && $stable(hold_q)));

endmodule

// File: tb/tb_mini_core_local_port_ctrl.sv
// Directed bench for mini_core_local_port_ctrl: arbitration fairness, back-pressure, RX FIFO order and reset.
module tb_mini_core_local_port_ctrl;
   import mini_core_pkg::*;

   localparam int NR = 3;
   localparam int RD = 4;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   t_tile_trans exp_q [$];

   always #5 clk = ~clk;

   mini_core_local_port_ctrl_if #(.NUM_REQ(NR), .RX_DEPTH(RD)) lp ();

   mini_core_local_port_ctrl #(.NUM_REQ(NR), .RX_DEPTH(RD)) dut (
      .clk (clk),
      .rst (rst),
      .lp  (lp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      lp.req_valid           = '0;
      lp.req_trans           = '0;
      lp.out_local_ready     = 4'b0000;
      lp.out_local_req_valid = 1'b0;
      lp.out_local_req       = '0;
      lp.rx_ready            = 1'b0;

      // reset held with all requesters valid: nothing may be accepted
      lp.req_valid       = 3'b111;
      for (int i = 0; i < NR; i++) lp.req_trans[i] = 32'h1000_0000 + 32'(i);
      lp.out_local_ready = 4'b1111;
      repeat (2) tick();
      #1;
      chk("rst_in_local_ready", 64'(lp.in_local_ready), 64'h0);
      chk("rst_inj_valid",      64'(lp.in_local_req_valid), 64'h0);
      chk("rst_inj_payload",    64'(lp.in_local_req), 64'h0);
      chk("rst_req_ready",      64'(lp.req_ready), 64'h0);
      chk("rst_grant_id",       64'(lp.grant_id), 64'd2);
      chk("rst_rx_count",       64'(lp.rx_count), 64'd0);
      chk("rst_rx_valid",       64'(lp.rx_valid), 64'h0);

      // first cycle after release
      rst = 1'b1;
      #1;
      chk("rel_req_ready",      64'(lp.req_ready), 64'b001);
      chk("rel_in_local_ready", 64'(lp.in_local_ready), 64'hF);
      chk("rel_inj_valid",      64'(lp.in_local_req_valid), 64'h0);

      // fairness: grants 0,1,2,0,1,2 back to back
      for (int k = 0; k < 6; k++) begin
         tick();
         chk("fair_grant",     64'(lp.grant_id), 64'(k % 3));
         chk("fair_payload",   64'(lp.in_local_req), 64'(32'h1000_0000 + 32'(k % 3)));
         chk("fair_valid",     64'(lp.in_local_req_valid), 64'h1);
         chk("fair_req_ready", 64'(lp.req_ready), 64'(1 << ((k + 1) % 3)));
      end

      // back-pressure: one router arbiter not ready for 5 cycles
      lp.out_local_ready = 4'b1011;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_payload",   64'(lp.in_local_req), 64'h1000_0002);
         chk("bp_req_ready", 64'(lp.req_ready), 64'h0);
         chk("bp_valid",     64'(lp.in_local_req_valid), 64'h1);
         tick();
      end
      lp.out_local_ready = 4'b1111;
      #1;
      chk("bp_release_ready", 64'(lp.req_ready), 64'b001);
      tick();
      lp.req_valid = 3'b100;
      #1;
      chk("bp_next_payload", 64'(lp.in_local_req), 64'h1000_0000);
      chk("bp_next_grant",   64'(lp.grant_id), 64'd0);

      // single requester 2, four transactions
      for (int k = 0; k < 4; k++) begin
         lp.req_trans[2] = 32'h2000_0000 + 32'(k);
         #1;
         chk("single_req_ready", 64'(lp.req_ready), 64'b100);
         tick();
         chk("single_payload", 64'(lp.in_local_req), 64'(32'h2000_0000 + 32'(k)));
         chk("single_grant",   64'(lp.grant_id), 64'd2);
      end
      lp.req_valid = 3'b000;
      #1;
      chk("single_last_ready", 64'(lp.req_ready), 64'h0);
      tick();
      chk("single_idle", 64'(lp.in_local_req_valid), 64'h0);

      // RX fill with no pops
      lp.out_local_req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         lp.out_local_req = 32'h3000_0000 + 32'(k);
         exp_q.push_back(lp.out_local_req);
         #1;
         chk("fill_count",       64'(lp.rx_count), 64'(k));
         chk("fill_local_ready", 64'(lp.in_local_ready), 64'hF);
         if (k == 0) chk("fill_rx_valid_first", 64'(lp.rx_valid), 64'h0);
         if (k == 1) chk("fill_rx_valid_next",  64'(lp.rx_valid), 64'h1);
         tick();
      end
      lp.out_local_req_valid = 1'b0;
      #1;
      chk("full_count",       64'(lp.rx_count), 64'd4);
      chk("full_local_ready", 64'(lp.in_local_ready), 64'h0);
      chk("full_head",        64'(lp.rx_trans), 64'(exp_q[0]));

      // two pops with no write
      for (int k = 0; k < 2; k++) begin
         lp.rx_ready = 1'b1;
         #1;
         chk("pop_head", 64'(lp.rx_trans), 64'(exp_q[0]));
         void'(exp_q.pop_front());
         tick();
         lp.rx_ready = 1'b0;
         #1;
         chk("pop_count",       64'(lp.rx_count), 64'(3 - k));
         chk("pop_local_ready", 64'(lp.in_local_ready), 64'hF);
         chk("pop_new_head",    64'(lp.rx_trans), 64'(exp_q[0]));
      end

      // simultaneous push and pop at count 2, then across the pointer wrap
      for (int k = 0; k < 7; k++) begin
         lp.out_local_req_valid = 1'b1;
         lp.out_local_req       = 32'h3000_0004 + 32'(k);
         lp.rx_ready            = 1'b1;
         #1;
         chk("pp_head", 64'(lp.rx_trans), 64'(exp_q[0]));
         void'(exp_q.pop_front());
         exp_q.push_back(lp.out_local_req);
         tick();
         chk("pp_count", 64'(lp.rx_count), 64'd2);
      end
      lp.out_local_req_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         lp.rx_ready = 1'b1;
         #1;
         chk("drain_head", 64'(lp.rx_trans), 64'(exp_q[0]));
         void'(exp_q.pop_front());
         tick();
      end
      lp.rx_ready = 1'b0;
      #1;
      chk("drain_count", 64'(lp.rx_count), 64'd0);
      chk("drain_valid", 64'(lp.rx_valid), 64'h0);

      // mid-operation reset while holding with 3 RX entries
      lp.out_local_req_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         lp.out_local_req = 32'h4000_0000 + 32'(k);
         tick();
      end
      lp.out_local_req_valid = 1'b0;
      lp.req_valid           = 3'b001;
      lp.req_trans[0]        = 32'h5000_0000;
      lp.out_local_ready     = 4'b0111;
      #1;
      chk("mid_req_ready", 64'(lp.req_ready), 64'b001);
      tick();
      lp.req_valid = 3'b000;
      #1;
      chk("mid_hold_valid", 64'(lp.in_local_req_valid), 64'h1);
      chk("mid_hold_data",  64'(lp.in_local_req), 64'h5000_0000);
      chk("mid_count",      64'(lp.rx_count), 64'd3);
      rst = 1'b0;
      tick();
      chk("mrst_inj_valid",   64'(lp.in_local_req_valid), 64'h0);
      chk("mrst_count",       64'(lp.rx_count), 64'd0);
      chk("mrst_grant",       64'(lp.grant_id), 64'd2);
      chk("mrst_local_ready", 64'(lp.in_local_ready), 64'h0);
      chk("mrst_payload",     64'(lp.in_local_req), 64'h0);
      rst = 1'b1;
      #1;
      chk("mrel_local_ready", 64'(lp.in_local_ready), 64'hF);
      chk("mrel_rx_valid",    64'(lp.rx_valid), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mini_core_local_port_ctrl.md
# mini_core_local_port_ctrl

Controller for a tile router's local port, sitting between the mini_core side of a tile and the router's local interface. It shares the single local injection port among NUM_REQ core-side requesters using a round-robin arbiter with a one-entry output holding register. It also buffers transactions the router ejects to the local port in an RX FIFO and back-pressures the router through the local ready vector.

## Interface
- NUM_REQ, default 3: number of core-side injection requesters (2..8).
- RX_DEPTH, default 4: RX FIFO entries; power of two, at least 2.
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  NUM_REQ  per-requester transaction valid.
- req_trans  in  NUM_REQ x t_tile_trans  per-requester transaction.
- req_ready  out  NUM_REQ  one-hot accept strobe, combinational.
- in_local_req_valid  out  1  injection valid to the router local input.
- in_local_req  out  t_tile_trans  injection payload.
- out_local_ready  in  t_fab_ready (4)  router per-arbiter ready for the local input.
- out_local_req_valid  in  1  router ejection valid.
- out_local_req  in  t_tile_trans  ejection payload.
- in_local_ready  out  t_fab_ready (4)  ready returned to the router for ejection.
- rx_valid  out  1  RX FIFO non-empty.
- rx_trans  out  t_tile_trans  RX FIFO head.
- rx_ready  in  1  core pops the RX head.
- rx_count  out  $clog2(RX_DEPTH+1)  RX occupancy.
- grant_id  out  $clog2(NUM_REQ)  index of the last accepted requester.

## Operation

**Injection state machine: IDLE and HOLD**
- inj_go = in_local_req_valid && (&out_local_ready).
  - Injection waits until all four router arbiters are ready; the controller does not decode direction.
- IDLE: in_local_req_valid = 0. If any req_valid is set:
  - pick the winner round-robin, searching from grant_id+1 with wrap modulo NUM_REQ;
  - assert req_ready[winner];
  - load the holding register, set grant_id = winner, move to HOLD.
- HOLD: in_local_req_valid = 1 and in_local_req is the holding register, stable until inj_go.
  - On inj_go with any req_valid: accept the next winner in the same cycle, reload, stay in HOLD. This gives back-to-back throughput of 1 per cycle.
  - On inj_go with no req_valid: go to IDLE.
  - Without inj_go: req_ready is all zero.
- A requester must keep req_valid and req_trans stable until req_ready. Deasserting before req_ready withdraws the request; this is legal.

**RX FIFO**
- Write when out_local_req_valid && count < RX_DEPTH.
- Read when rx_valid && rx_ready.
- rx_valid = (count != 0); rx_trans = mem[rd_ptr]. There is no write-to-read bypass.
- in_local_ready = 4'b1111 when count < RX_DEPTH, else 4'b0000. It is derived from registered count only.
- rd_ptr and wr_ptr wrap modulo RX_DEPTH.
- Simultaneous read and write: count is unchanged and both pointers advance.
- out_local_req_valid while full is a router protocol violation: the data is dropped, count does not change, and an assertion fires.

## Timing
- Reset values while rst = 0, and on the first cycle after release:
  - state = IDLE, grant_id = NUM_REQ-1 so requester 0 has first priority;
  - in_local_req_valid = 0, in_local_req = '0, req_ready = '0;
  - count = 0, pointers = 0, rx_valid = 0;
  - in_local_ready = 4'b0000 while rst = 0, and 4'b1111 from the first cycle after release.
- Injection latency: accepted at edge N (req_ready high in cycle N-1), in_local_req_valid high from cycle N. Minimum 1 cycle, request to router.
- RX latency: written at edge N, rx_valid high in cycle N+1.
- Reset mid-operation: the holding register and FIFO contents are discarded and requesters must reissue. Reset takes priority over all events in the same cycle.
- No combinational path from out_local_ready or out_local_req_valid to in_local_ready.
- req_ready depends combinationally on req_valid, state and out_local_ready.

## Test plan
- Reset fairness:
  - stimulus: release rst with all three req_valid high and out_local_ready = 4'b1111;
  - required: grants 0,1,2,0,… on consecutive cycles; in_local_req_valid stays high; one transfer per cycle.
- Back-pressure:
  - stimulus: out_local_ready = 4'b1011 for 5 cycles while in HOLD with payload P;
  - required: in_local_req = P stable for all 5 cycles, req_ready = 0; P transfers on the cycle ready returns to 4'b1111.
- Single requester:
  - stimulus: only req 2 valid, for 4 transactions;
  - required: grant_id = 2 each time; return to IDLE after the last transfer.
- RX fill:
  - stimulus: 4 ejections with rx_ready = 0;
  - required: count 1..4; in_local_ready = 4'b0000 after the 4th write.
  - then: pop 1 with no write; count = 3 and in_local_ready = 4'b1111 next cycle; FIFO order preserved, including across wrap after 6 more pushes and pops.
- Simultaneous RX push and pop:
  - stimulus: push and pop in the same cycle at count = 2;
  - required: count stays 2 and the head advances.
  - stimulus: push at count = 0;
  - required: rx_valid only in the next cycle.
- Mid-operation reset:
  - stimulus: assert rst while in HOLD with count = 3;
  - required: next cycle in_local_req_valid = 0, count = 0, grant_id = NUM_REQ-1.
